bcd_convert_sequencer: RTL and testbench

Sequential replacement for the combinational divide-based decimal-to-BCD stage in the calculator display path. It accepts a 16-bit unsigned magnitude plus sign and error flags on a start pulse. It converts the value with a 16-iteration shift-add-3 (double-dabble) sequence and presents four registered BCD digits with a done pulse. It sits between the ALU/memory result register and the seven-segment scan driver, and removes the divider chain from the timing path.

---
 rtl/bcd_convert_sequencer.sv | 166 ++++++++++++++++
 tb/tb_bcd_convert_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_sequencer.sv
// rtl/bcd_convert_sequencer.sv - sequential 16-bit binary to 4-digit BCD converter (double-dabble)
//
// Converts a 16-bit unsigned magnitude to four registered BCD digits using
// 16 shift-add-3 iterations, one per clock. Values above 9999 saturate to 9999
// and raise overflow. An error request skips the conversion and holds the digits.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   start          conversion request, sampled only while idle
//   decimal[15:0]  magnitude to convert, captured on accepted start
//   negative       sign, captured on accepted start
//   error          calculator error flag, captured on accepted start
//   bcd3..bcd0     thousands..ones digits (registered)
//   negative_sign  registered captured sign
//   error_flag     registered captured error
//   overflow       captured magnitude exceeded 9999
//   busy           high while converting or presenting done
//   done           one-cycle pulse, results valid from this cycle

module bcd_convert_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] decimal,
  input  logic        negative,
  input  logic        error,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd0,
  output logic        negative_sign,
  output logic        error_flag,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] shift_reg;
  logic [19:0] acc;
  logic [3:0]  iter;
  logic        neg_cap;

  logic [19:0] acc_adj;
  logic [19:0] acc_next;
  logic [15:0] shift_next;
  logic        last_iter;

  assign last_iter = (iter == 4'd15);

  // Add-3 correction per digit, each 4-bit with no carry between digits,
  // followed by the combined left shift of {accumulator, shift register}.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 5; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    acc_next   = {acc_adj[18:0], shift_reg[15]};
    shift_next = {shift_reg[14:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = error ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg     <= 16'd0;
      acc           <= 20'd0;
      iter          <= 4'd0;
      neg_cap       <= 1'b0;
      bcd3          <= 4'd0;
      bcd2          <= 4'd0;
      bcd1          <= 4'd0;
      bcd0          <= 4'd0;
      negative_sign <= 1'b0;
      error_flag    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (error) begin
              // Error path: digits and overflow deliberately keep old values.
              negative_sign <= negative;
              error_flag    <= 1'b1;
            end else begin
              shift_reg <= decimal;
              acc       <= 20'd0;
              iter      <= 4'd0;
              neg_cap   <= negative;
            end
          end
        end
        S_SHIFT: begin
          acc       <= acc_next;
          shift_reg <= shift_next;
          iter      <= iter + 4'd1;
          if (last_iter) begin
            negative_sign <= neg_cap;
            error_flag    <= 1'b0;
            // A non-zero fifth digit means the value exceeded 9999.
            if (acc_next[19:16] != 4'd0) begin
              bcd3     <= 4'd9;
              bcd2     <= 4'd9;
              bcd1     <= 4'd9;
              bcd0     <= 4'd9;
              overflow <= 1'b1;
            end else begin
              bcd3     <= acc_next[15:12];
              bcd2     <= acc_next[11:8];
              bcd1     <= acc_next[7:4];
              bcd0     <= acc_next[3:0];
              overflow <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// tb/tb_bcd_convert_sequencer.sv - directed self-checking bench for bcd_convert_sequencer

module tb_bcd_convert_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] decimal;
  logic        negative;
  logic        error;
  logic [3:0]  bcd3, bcd2, bcd1, bcd0;
  logic        negative_sign, error_flag, overflow, busy, done;

  int passed = 0;
  int total  = 0;

  bcd_convert_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .decimal(decimal),
    .negative(negative), .error(error),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .negative_sign(negative_sign), .error_flag(error_flag),
    .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one start and waits for done; lat is the sample index of done
  // counted from the first sample after the start edge (-1 on timeout).
  task automatic convert(input logic [15:0] d, input logic n, input logic e,
                         output int lat, output int busy_cnt);
    decimal  = d;
    negative = n;
    error    = e;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    error    = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; decimal = 16'd0; negative = 1'b0; error = 1'b0;
    tick(); tick();
    reset = 1'b0;
    total++; if ({bcd3, bcd2, bcd1, bcd0} !== 16'h0000) $display("FAIL reset_bcd got %h exp 0000", {bcd3, bcd2, bcd1, bcd0}); else passed++;
    total++; if ({negative_sign, error_flag, overflow} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {negative_sign, error_flag, overflow}); else passed++;
    total++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got %b exp 00", {busy, done}); else passed++;
  endtask

  task automatic test_basic;
    int lat, bc;
    convert(16'd1234, 1'b0, 1'b0, lat, bc);
    total++; if (lat !== 16) $display("FAIL basic_latency got %0d exp 16", lat); else passed++;
    total++; if (bc !== 17) $display("FAIL basic_busy_cycles got %0d exp 17", bc); else passed++;
    total++; if ({bcd3, bcd2, bcd1, bcd0} !== 16'h1234) $display("FAIL basic_bcd got %h exp 1234", {bcd3, bcd2, bcd1, bcd0}); else passed++;
    total++; if ({negative_sign, error_flag, overflow} !== 3'b000) $display("FAIL basic_flags got %b exp 000", {negative_sign, error_flag, overflow}); else passed++;
    total++; if ({busy, done} !== 2'b00) $display("FAIL basic_after_done got %b exp 00", {busy, done}); else passed++;
  endtask

  task automatic test_saturate;
    int lat, bc;
    convert(16'd9999, 1'b1, 1'b0, lat, bc);
    total++; if ({bcd3, bcd2, bcd1, bcd0} !== 16'h9999) $display("FAIL sat9999_bcd got %h exp 9999", {bcd3, bcd2, bcd1, bcd0}); else passed++;
    total++; if ({negative_sign, overflow} !== 2'b10) $display("FAIL sat9999_neg_ovf got %b exp 10", {negative_sign, overflow}); else passed++;
    convert(16'd10000, 1'b0, 1'b0, lat, bc);
    total++; if ({bcd3, bcd2, bcd1, bcd0} !== 16'h9999) $display("FAIL sat10000_bcd got %h exp 9999", {bcd3, bcd2, bcd1, bcd0}); else passed++;
    total++; if ({negative_sign, overflow} !== 2'b01) $display("FAIL sat10000_neg_ovf got %b exp 01", {negative_sign, overflow}); else passed++;
    convert(16'd65535, 1'b0, 1'b0, lat, bc);
    total++; if ({bcd3, bcd2, bcd1, bcd0} !== 16'h9999) $display("FAIL sat65535_bcd got %h exp 9999", {bcd3, bcd2, bcd1, bcd0}); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL sat65535_ovf got %b exp 1", overflow); else passed++;
  endtask

  task automatic test_error;
    int lat, bc;
    // Error straight after an overflowed result: overflow and digits must hold.
    convert(16'd1, 1'b1, 1'b1, lat, bc);
    total++; if (lat !== 0) $display("FAIL err1_latency got %0d exp 0", lat); else passed++;
    total++; if (bc !== 1) $display("FAIL err1_busy_cycles got %0d exp 1", bc); else passed++;
    total++; if ({bcd3, bcd2, bcd1, bcd0} !== 16'h9999) $display("FAIL err1_bcd_hold got %h exp 9999", {bcd3, bcd2, bcd1, bcd0}); else passed++;
    total++; if ({negative_sign, error_flag, overflow} !== 3'b111) $display("FAIL err1_flags got %b exp 111", {negative_sign, error_flag, overflow}); else passed++;
    convert(16'd42, 1'b0, 1'b0, lat, bc);
    total++; if ({bcd3, bcd2, bcd1, bcd0} !== 16'h0042) $display("FAIL conv42_bcd got %h exp 0042", {bcd3, bcd2, bcd1, bcd0}); else passed++;
    total++; if ({negative_sign, error_flag, overflow} !== 3'b000) $display("FAIL conv42_flags got %b exp 000", {negative_sign, error_flag, overflow}); else passed++;
    convert(16'd7777, 1'b0, 1'b1, lat, bc);
    total++; if (lat !== 0) $display("FAIL err2_latency got %0d exp 0", lat); else passed++;
    total++; if ({bcd3, bcd2, bcd1, bcd0} !== 16'h0042) $display("FAIL err2_bcd_hold got %h exp 0042", {bcd3, bcd2, bcd1, bcd0}); else passed++;
    total++; if ({error_flag, overflow} !== 2'b10) $display("FAIL err2_flags got %b exp 10", {error_flag, overflow}); else passed++;
  endtask

  task automatic test_ignore_start;
    int n_done;
    n_done   = 0;
    decimal  = 16'd500;
    negative = 1'b0;
    error    = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) begin start = 1'b1; decimal = 16'd123; end
      if (i == 5) start = 1'b0;
      if (i == 8) decimal = 16'd9999;
      if (done) n_done++;
      tick();
    end
    total++; if (n_done !== 1) $display("FAIL ignore_done_count got %0d exp 1", n_done); else passed++;
    total++; if ({bcd3, bcd2, bcd1, bcd0} !== 16'h0500) $display("FAIL ignore_bcd got %h exp 0500", {bcd3, bcd2, bcd1, bcd0}); else passed++;
  endtask

  task automatic test_reset_abort;
    int n_done, lat, bc;
    n_done  = 0;
    decimal = 16'd3210;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if ({bcd3, bcd2, bcd1, bcd0} !== 16'h0000) $display("FAIL abort_bcd got %h exp 0000", {bcd3, bcd2, bcd1, bcd0}); else passed++;
    total++; if ({busy, done, negative_sign, error_flag, overflow} !== 5'b00000) $display("FAIL abort_ctrl got %b exp 00000", {busy, done, negative_sign, error_flag, overflow}); else passed++;
    for (int i = 0; i < 25; i++) begin
      if (done) n_done++;
      tick();
    end
    total++; if (n_done !== 0) $display("FAIL abort_no_done got %0d exp 0", n_done); else passed++;
    convert(16'd7, 1'b0, 1'b0, lat, bc);
    total++; if (lat !== 16) $display("FAIL conv7_latency got %0d exp 16", lat); else passed++;
    total++; if ({bcd3, bcd2, bcd1, bcd0} !== 16'h0007) $display("FAIL conv7_bcd got %h exp 0007", {bcd3, bcd2, bcd1, bcd0}); else passed++;
  endtask

  task automatic test_back_to_back;
    int n_done, first, second, wide;
    logic prev;
    n_done = 0; first = -1; second = -1; wide = 0; prev = 1'b0;
    decimal  = 16'd0;
    negative = 1'b0;
    error    = 1'b0;
    start    = 1'b1;
    tick();
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        if (prev) wide++;
        if (n_done == 0) first = i;
        if (n_done == 1) second = i;
        n_done++;
      end
      prev = done;
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    total++; if (n_done !== 3) $display("FAIL b2b_done_count got %0d exp 3", n_done); else passed++;
    total++; if (first !== 16) $display("FAIL b2b_first_done got %0d exp 16", first); else passed++;
    total++; if (second - first !== 18) $display("FAIL b2b_spacing got %0d exp 18", second - first); else passed++;
    total++; if (wide !== 0) $display("FAIL b2b_pulse_width got %0d exp 0", wide); else passed++;
    total++; if ({bcd3, bcd2, bcd1, bcd0} !== 16'h0000) $display("FAIL b2b_bcd got %h exp 0000", {bcd3, bcd2, bcd1, bcd0}); else passed++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; decimal = 16'd0; negative = 1'b0; error = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_error();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
